// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption engine: one full cipher round per clock with the
// round key expanded on the fly, between a plaintext/key stream and a ciphertext stream.
module aes128_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } fsm_t;

    localparam logic [3:0] NR_LAST = 4'(NR);

    // Forward S-box, row-major: entry x lives at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {x, 3'b000};
        return SBOX[11'd2047 - idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    fsm_t         r_fsm;
    logic [127:0] r_blk;
    logic [127:0] r_key;
    logic [7:0]   r_rcon;
    logic [3:0]   r_round;
    logic         r_out_valid;
    logic [127:0] r_out_data;

    logic [7:0]   w_sub [16];
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [31:0]  w_rot;
    logic [31:0]  w_ksub;
    logic [31:0]  w_k0, w_k1, w_k2, w_k3;
    logic [127:0] w_next_key;
    logic [127:0] w_round_out;
    logic         w_last;
    logic         w_accept;

    // SubBytes then ShiftRows: byte (row r, col c) takes the byte from col (c+r)%4.
    for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
        assign w_sub[gi] = sbox(r_blk[127-8*gi -: 8]);
        assign w_shift[127-8*gi -: 8] = w_sub[SRC];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mix
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_shift[127-32*gi -: 8];
        assign w_a1 = w_shift[119-32*gi -: 8];
        assign w_a2 = w_shift[111-32*gi -: 8];
        assign w_a3 = w_shift[103-32*gi -: 8];
        assign w_mix[127-32*gi -: 32] = {
            xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
            w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
            w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
            xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
        };
    end

    assign w_rot = {r_key[23:0], r_key[31:24]};
    for (genvar gi = 0; gi < 4; gi++) begin : g_key_sub
        assign w_ksub[31-8*gi -: 8] = sbox(w_rot[31-8*gi -: 8]);
    end

    assign w_k0       = r_key[127:96] ^ w_ksub ^ {r_rcon, 24'h0};
    assign w_k1       = r_key[95:64] ^ w_k0;
    assign w_k2       = r_key[63:32] ^ w_k1;
    assign w_k3       = r_key[31:0] ^ w_k2;
    assign w_next_key = {w_k0, w_k1, w_k2, w_k3};

    assign w_last      = (r_round == NR_LAST);
    assign w_round_out = (w_last ? w_shift : w_mix) ^ w_next_key;

    // DONE can hand off straight to a new block when the consumer takes the result.
    assign in_ready  = (r_fsm == S_IDLE) || ((r_fsm == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign busy      = (r_fsm != S_IDLE);
    assign round_idx = r_round;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= S_IDLE;
            r_blk       <= '0;
            r_key       <= '0;
            r_rcon      <= '0;
            r_round     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (w_accept) begin
                        r_blk   <= in_data ^ in_key;
                        r_key   <= in_key;
                        r_rcon  <= 8'h01;
                        r_round <= 4'd1;
                        r_fsm   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_blk   <= w_round_out;
                    r_key   <= w_next_key;
                    r_rcon  <= xtime(r_rcon);
                    r_round <= r_round + 4'd1;
                    if (w_last) begin
                        r_fsm       <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_round_out;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_blk   <= in_data ^ in_key;
                            r_key   <= in_key;
                            r_rcon  <= 8'h01;
                            r_round <= 4'd1;
                            r_fsm   <= S_ROUND;
                        end else begin
                            r_round <= 4'd0;
                            r_fsm   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Self-checking bench for aes128_round_ctrl: FIPS-197 vectors, random blocks against
// a byte-level AES model, backpressure, back-to-back, busy-input and mid-round reset.
module tb_aes128_round_ctrl;

    localparam int NR = 10;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   round_idx;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] sb [256];

    aes128_round_ctrl #(.NR(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---- reference model: GF(2^8) arithmetic, S-box from inverse + affine map ----
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0] w [4*(NR+1)];
        logic [7:0]  st [16];
        logic [7:0]  tmp [16];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= NR; rnd++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sb[st[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rnd == NR)
                        st[4*c+r] = tmp[4*c+r];
                    else
                        st[4*c+r] = gmul(8'h02, tmp[4*c+r]) ^ gmul(8'h03, tmp[4*c+(r+1)%4])
                                  ^ tmp[4*c+(r+2)%4] ^ tmp[4*c+(r+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block with out_ready held high; optionally jiggles inputs and pulses in_valid mid-round.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp, input string tag, input bit disturb);
        int lat;
        out_ready = 1'b1;
        in_data   = pt;
        in_key    = key;
        in_valid  = 1'b1;
        #1 chk({tag, " accept_ready"}, 128'(in_ready), 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rnd128();
        in_key   = rnd128();
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (disturb) begin
                in_data  = rnd128();
                in_key   = rnd128();
                in_valid = (lat >= 3 && lat <= 5);
            end
            #1;
            chk({tag, " round_idx"}, 128'(round_idx), 128'(lat));
            chk({tag, " busy"}, 128'(busy), 128'd1);
            chk({tag, " in_ready_round"}, 128'(in_ready), 128'd0);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, 128'(lat), 128'(NR + 1));
        chk({tag, " ciphertext"}, out_data, exp);
        @(negedge clk);
        chk({tag, " out_valid_drop"}, 128'(out_valid), 128'd0);
        chk({tag, " idle_round_idx"}, 128'(round_idx), 128'd0);
        chk({tag, " idle_busy"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int t;
        logic [127:0] pt, key, exp;

        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset out_valid", 128'(out_valid), 128'd0);
        chk("reset out_data", out_data, 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset round_idx", 128'(round_idx), 128'd0);
        rst_n = 1'b1;
        #1 chk("reset in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);

        // Known-answer vectors
        run_block(C1_PT, C1_KEY, C1_CT, "c1", 1'b0);
        run_block(B_PT, B_KEY, B_CT, "appB", 1'b0);

        // Random blocks against the model
        for (int n = 0; n < 6; n++) begin
            pt  = rnd128();
            key = rnd128();
            run_block(pt, key, aes_ref(pt, key), $sformatf("rand%0d", n), 1'b0);
        end

        // Inputs changing and in_valid pulsing while busy
        run_block(C1_PT, C1_KEY, C1_CT, "busy_ignore", 1'b1);

        // Backpressure
        pt  = rnd128();
        key = rnd128();
        exp = aes_ref(pt, key);
        out_ready = 1'b0;
        in_data = pt; in_key = key; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        t = 1;
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("bp latency", 128'(t), 128'(NR + 1));
        for (int c = 0; c < 20; c++) begin
            in_data = rnd128();
            chk("bp out_valid", 128'(out_valid), 128'd1);
            chk("bp out_data", out_data, exp);
            chk("bp in_ready", 128'(in_ready), 128'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release out_valid", 128'(out_valid), 128'd0);
        chk("bp release busy", 128'(busy), 128'd0);

        // Back-to-back: C.1 then App. B with in_valid held high
        out_ready = 1'b1;
        in_data = C1_PT; in_key = C1_KEY; in_valid = 1'b1;
        @(negedge clk);
        in_data = B_PT; in_key = B_KEY;
        t = 1;
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("b2b first latency", 128'(t), 128'(NR + 1));
        chk("b2b first ct", out_data, C1_CT);
        #1 chk("b2b done in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b reload round_idx", 128'(round_idx), 128'd1);
        chk("b2b reload out_valid", 128'(out_valid), 128'd0);
        t = 1;
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("b2b second spacing", 128'(t), 128'(NR + 1));
        chk("b2b second ct", out_data, B_CT);
        @(negedge clk);
        chk("b2b final out_valid", 128'(out_valid), 128'd0);

        // Reset mid-round
        out_ready = 1'b1;
        in_data = B_PT; in_key = B_KEY; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (round_idx != 4'd5 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("rst reached round5", 128'(round_idx), 128'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("rst async out_valid", 128'(out_valid), 128'd0);
        chk("rst async busy", 128'(busy), 128'd0);
        chk("rst async round_idx", 128'(round_idx), 128'd0);
        chk("rst async out_data", out_data, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst no partial out", 128'(out_valid), 128'd0);
        end
        run_block(B_PT, B_KEY, B_CT, "after_rst", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
Iterative AES-128 encryption engine controller. Sequences one full cipher round per clock through the team's ShiftRows block, a local S-box/SubBytes stage, MixColumns and AddRoundKey, expanding the round key on the fly. Sits between the block-level valid/ready input stream and the ciphertext output stream. Processes one 128-bit block at a time.

Parameters:
NR, 10, number of cipher rounds. Only 10 is legal in production. Other values exist for bench use; the last round always omits MixColumns.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  plaintext/key offered
in_ready  output  1  block accepts plaintext/key this cycle
in_data  input  128  plaintext; byte 0 at [127:120], column-major (FIPS-197 order)
in_key  input  128  cipher key, same byte order
out_valid  output  1  ciphertext available
out_ready  input  1  consumer accepts ciphertext
out_data  output  128  ciphertext, same byte order
busy  output  1  high in ROUND or DONE
round_idx  output  4  current round number, 0 when idle

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; state and round-key registers = 0; round_idx=0; out_valid=0; out_data=0; busy=0; in_ready=1 after release. Reset asserted mid-operation aborts the block silently; no partial output.
- States: IDLE, ROUND, DONE.
- IDLE: in_ready=1.
  - On in_valid: state_reg <= in_data ^ in_key (initial AddRoundKey); key_reg <= in_key; rcon <= 8'h01; round_idx <= 1; go to ROUND.
- ROUND, cycles with round_idx = 1..NR:
  - next_key = KeyExpand(key_reg, rcon): w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), next_key); MixColumns is bypassed when round_idx == NR.
  - key_reg <= next_key; rcon <= xtime(rcon), so 8'h80 advances to 8'h1b.
  - round_idx increments each cycle.
  - When round_idx == NR: go to DONE, out_valid <= 1, out_data <= final state.
  - in_ready=0 throughout ROUND; in_valid is ignored.
- DONE: out_valid=1; out_data held stable until handshake.
  - On out_ready with in_valid=0: out_valid <= 0; round_idx <= 0; go to IDLE.
  - On out_ready with in_valid=1: in_ready=1 this cycle. The new block is loaded exactly as in IDLE and the state goes directly to ROUND (back-to-back, no bubble).
  - Without out_ready: hold indefinitely.
- Latency: acceptance at cycle T gives out_valid high at T+NR+1 (11 cycles for AES-128). Sustained throughput is one block per NR+1 cycles.
- in_ready is combinational: (state==IDLE) || (state==DONE && out_ready). No other combinational input-to-output paths.
- in_data and in_key are sampled only on an accepted handshake. Changes at any other time have no effect.
- All arithmetic is GF(2^8) with polynomial 0x11b. No carries or widening.

Test Plan:
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1 -> out_valid exactly 11 cycles after acceptance, out_data = 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data = 3925841d02dc09fbdc118597196a0b32. round_idx steps 1..10 during ROUND.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_valid and out_data stable and in_ready=0 throughout. out_ready=1 for one cycle -> out_valid drops next cycle.
- Back-to-back: App. C.1 then App. B vectors with in_valid held high and out_ready=1 -> second block accepted in the DONE cycle, second out_valid 11 cycles after the first. Both ciphertexts correct.
- Input ignored while busy: change in_data/in_key and pulse in_valid during ROUND -> in_ready=0 and the C.1 ciphertext is unchanged.
- Reset mid-round: assert rst_n=0 at round_idx=5 -> out_valid/busy/round_idx = 0 immediately, without waiting for a clock edge. After release, a fresh App. B encryption produces the correct ciphertext.
